// File: rtl/m_mem_arb_if.sv
// Requester-side and memory-side signal bundle shared by the arbiter and its environment.
// The arbiter uses the slave view; the pipeline/memory environment uses the master view.
interface m_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              w_ireq;
    logic [ADDR_W-1:0] w_iaddr;
    logic              w_iflush;
    logic              w_iack;
    logic [DATA_W-1:0] w_irdata;
    logic              w_dreq;
    logic              w_dwe;
    logic [ADDR_W-1:0] w_daddr;
    logic [DATA_W-1:0] w_dwdata;
    logic              w_dack;
    logic [DATA_W-1:0] w_drdata;
    logic              w_mreq;
    logic              w_mwe;
    logic [ADDR_W-1:0] w_maddr;
    logic [DATA_W-1:0] w_mwdata;
    logic              w_mack;
    logic [DATA_W-1:0] w_mrdata;
    logic              w_stall_if;
    logic              w_stall_mem;

    modport slave (
        input  w_ireq, w_iaddr, w_iflush, w_dreq, w_dwe, w_daddr, w_dwdata, w_mack, w_mrdata,
        output w_iack, w_irdata, w_dack, w_drdata, w_mreq, w_mwe, w_maddr, w_mwdata,
               w_stall_if, w_stall_mem
    );

    modport master (
        output w_ireq, w_iaddr, w_iflush, w_dreq, w_dwe, w_daddr, w_dwdata, w_mack, w_mrdata,
        input  w_iack, w_irdata, w_dack, w_drdata, w_mreq, w_mwe, w_maddr, w_mwdata,
               w_stall_if, w_stall_mem
    );
endinterface

// File: rtl/m_mem_arb.sv
// Fetch/data arbiter in front of a single-ported variable-latency memory: data has priority,
// fetch is guaranteed a grant after STARVE consecutive data wins, and flushed fetches are dropped.
module m_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STARVE = 4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    m_mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, IDROP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mreq_q, mreq_d;
    logic              mwe_q, mwe_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic              iack, dack;
    logic              fetch_cand;

    assign fetch_cand = bus.w_ireq & ~bus.w_iflush;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        iack     = 1'b0;
        dack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.w_dreq && (!fetch_cand || (cnt_q < 4'(STARVE)))) begin
                    state_d  = DBUSY;
                    mreq_d   = 1'b1;
                    mwe_d    = bus.w_dwe;
                    maddr_d  = bus.w_daddr;
                    mwdata_d = bus.w_dwdata;
                    // Only wins taken over a waiting fetch count toward starvation.
                    if (fetch_cand)
                        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                end else if (fetch_cand) begin
                    state_d  = IBUSY;
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b0;
                    maddr_d  = bus.w_iaddr;
                    mwdata_d = '0;
                    cnt_d    = '0;
                end
            end
            IBUSY: begin
                if (bus.w_mack) begin
                    iack    = ~bus.w_iflush;
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.w_iflush) begin
                    state_d = IDROP;
                end
            end
            DBUSY: begin
                if (bus.w_mack) begin
                    dack    = 1'b1;
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            IDROP: begin
                // The memory cannot be aborted, so the cancelled read runs to completion silently.
                if (bus.w_mack) begin
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.w_mreq      = mreq_q;
    assign bus.w_mwe       = mwe_q;
    assign bus.w_maddr     = maddr_q;
    assign bus.w_mwdata    = mwdata_q;
    assign bus.w_iack      = iack;
    assign bus.w_dack      = dack;
    assign bus.w_irdata    = iack ? bus.w_mrdata : '0;
    assign bus.w_drdata    = dack ? bus.w_mrdata : '0;
    assign bus.w_stall_if  = bus.w_ireq & ~iack;
    assign bus.w_stall_mem = bus.w_dreq & ~dack;
endmodule

// File: tb/tb_m_mem_arb.sv
// Directed bench for m_mem_arb: a wait-state memory model answers with data = address ^ 7.
module tb_m_mem_arb;
    logic w_clk = 1'b0;
    logic w_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int unsigned mem_wait = 0;
    int unsigned wcnt = 0;

    m_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    m_mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE(4)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    always #5 w_clk = ~w_clk;

    // Memory: acks on the (mem_wait+1)-th cycle of a request.
    always @(posedge w_clk) begin
        if (!bus.w_mreq || bus.w_mack) wcnt <= 0;
        else                           wcnt <= wcnt + 1;
    end
    assign bus.w_mack   = bus.w_mreq && (wcnt == mem_wait);
    assign bus.w_mrdata = bus.w_mreq ? (bus.w_maddr ^ 32'h7) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge w_clk);
    endtask

    // Entered at the first w_mreq cycle of a granted transaction; returns in its ack cycle.
    task automatic run_txn(input string tag, input bit is_d, input logic [31:0] addr,
                           input bit we, input logic [31:0] wd, input int nwait);
        for (int i = 0; i <= nwait; i++) begin
            if (i > 0) cyc();
            chk({tag, ".mreq"}, bus.w_mreq, 32'd1);
            chk({tag, ".maddr"}, bus.w_maddr, addr);
            chk({tag, ".mwe"}, bus.w_mwe, {31'd0, we});
            if (is_d && we) chk({tag, ".mwdata"}, bus.w_mwdata, wd);
            if (is_d) begin
                chk({tag, ".dack"}, bus.w_dack, {31'd0, i == nwait});
                chk({tag, ".iack"}, bus.w_iack, 32'd0);
                if (i == nwait) chk({tag, ".drdata"}, bus.w_drdata, addr ^ 32'h7);
            end else begin
                chk({tag, ".iack"}, bus.w_iack, {31'd0, i == nwait});
                chk({tag, ".dack"}, bus.w_dack, 32'd0);
                if (i == nwait) chk({tag, ".irdata"}, bus.w_irdata, addr ^ 32'h7);
            end
        end
        $display("txn %s %s addr=0x%08h we=%0d waits=%0d", tag, is_d ? "data" : "fetch",
                 addr, we, nwait);
    endtask

    // Fetch and data both requesting continuously from an IDLE cycle with cnt=0:
    // expected grant pattern is four data wins, then one fetch, repeating.
    task automatic run_starve(input string tag, input int ntx);
        logic [31:0] da;
        mem_wait = 0;
        bus.w_ireq = 1'b1; bus.w_iaddr = 32'h30;
        bus.w_dreq = 1'b1; bus.w_dwe = 1'b0;
        for (int k = 0; k < ntx; k++) begin
            da = 32'h200 + 32'(k) * 4;
            bus.w_daddr = da;
            chk($sformatf("%s.idle%0d", tag, k), bus.w_mreq, 32'd0);
            cyc();
            if ((k % 5) != 4) run_txn($sformatf("%s.d%0d", tag, k), 1'b1, da, 1'b0, 32'h0, 0);
            else              run_txn($sformatf("%s.i%0d", tag, k), 1'b0, 32'h30, 1'b0, 32'h0, 0);
            if (k == ntx - 1) begin
                bus.w_ireq = 1'b0;
                bus.w_dreq = 1'b0;
            end
            cyc();
        end
    endtask

    initial begin
        bus.w_ireq = 1'b0; bus.w_iaddr = '0; bus.w_iflush = 1'b0;
        bus.w_dreq = 1'b0; bus.w_dwe = 1'b0; bus.w_daddr = '0; bus.w_dwdata = '0;

        // Reset state
        cyc();
        chk("rst.mreq", bus.w_mreq, 32'd0);
        chk("rst.mwe", bus.w_mwe, 32'd0);
        chk("rst.maddr", bus.w_maddr, 32'd0);
        chk("rst.mwdata", bus.w_mwdata, 32'd0);
        chk("rst.iack", bus.w_iack, 32'd0);
        chk("rst.dack", bus.w_dack, 32'd0);
        w_rst_n = 1'b1;
        cyc();

        // Single fetch, zero-wait memory
        mem_wait = 0;
        bus.w_ireq = 1'b1; bus.w_iaddr = 32'h14;
        #1;
        chk("f0.stall_req", bus.w_stall_if, 32'd1);
        chk("f0.mreq_pre", bus.w_mreq, 32'd0);
        cyc();
        run_txn("f0", 1'b0, 32'h14, 1'b0, 32'h0, 0);
        chk("f0.irdata13", bus.w_irdata, 32'h13);
        chk("f0.stall_ack", bus.w_stall_if, 32'd0);
        bus.w_ireq = 1'b0;
        cyc();
        chk("f0.mreq_post", bus.w_mreq, 32'd0);
        chk("f0.iack_post", bus.w_iack, 32'd0);

        // Simultaneous requests, 3-wait memory: store wins, then fetch
        mem_wait = 3;
        bus.w_ireq = 1'b1; bus.w_iaddr = 32'h20;
        bus.w_dreq = 1'b1; bus.w_dwe = 1'b1; bus.w_daddr = 32'h100; bus.w_dwdata = 32'hDEADBEEF;
        #1;
        chk("sim.stall_mem", bus.w_stall_mem, 32'd1);
        cyc();
        run_txn("sim.st", 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 3);
        bus.w_dreq = 1'b0; bus.w_dwe = 1'b0;
        cyc();
        chk("sim.gap", bus.w_mreq, 32'd0);
        cyc();
        run_txn("sim.if", 1'b0, 32'h20, 1'b0, 32'h0, 3);
        bus.w_ireq = 1'b0;
        cyc();

        // Starvation guard
        run_starve("stv", 6);

        // Flush in the 2nd wait cycle of a 5-wait fetch
        mem_wait = 5;
        bus.w_ireq = 1'b1; bus.w_iaddr = 32'h34;
        cyc();
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) cyc();
            if (i == 1) begin
                bus.w_iflush = 1'b1;
                bus.w_iaddr  = 32'h40;
                #1;
            end
            if (i == 2) bus.w_iflush = 1'b0;
            chk($sformatf("fl.mreq%0d", i), bus.w_mreq, 32'd1);
            chk($sformatf("fl.maddr%0d", i), bus.w_maddr, 32'h34);
            chk($sformatf("fl.iack%0d", i), bus.w_iack, 32'd0);
        end
        chk("fl.stall", bus.w_stall_if, 32'd1);
        cyc();
        mem_wait = 0;
        chk("fl.idle", bus.w_mreq, 32'd0);
        cyc();
        run_txn("fl.new", 1'b0, 32'h40, 1'b0, 32'h0, 0);
        bus.w_ireq = 1'b0;
        cyc();

        // Flush together with w_mack, then flush masking a fetch in IDLE
        mem_wait = 2;
        bus.w_ireq = 1'b1; bus.w_iaddr = 32'h50;
        cyc();
        cyc();
        cyc();
        chk("fm.mack", bus.w_mack, 32'd1);
        bus.w_iflush = 1'b1;
        #1;
        chk("fm.iack", bus.w_iack, 32'd0);
        chk("fm.irdata", bus.w_irdata, 32'd0);
        cyc();
        chk("fm.idle", bus.w_mreq, 32'd0);
        cyc();
        chk("fm.nogrant", bus.w_mreq, 32'd0);
        bus.w_iflush = 1'b0; bus.w_ireq = 1'b0;
        cyc();

        // Asynchronous reset while a data grant (taken over a waiting fetch) is in DBUSY
        mem_wait = 5;
        bus.w_ireq = 1'b1; bus.w_iaddr = 32'h60;
        bus.w_dreq = 1'b1; bus.w_dwe = 1'b1; bus.w_daddr = 32'h80; bus.w_dwdata = 32'h12345678;
        cyc();
        chk("ar.mreq", bus.w_mreq, 32'd1);
        chk("ar.maddr", bus.w_maddr, 32'h80);
        cyc();
        #2;
        w_rst_n = 1'b0;
        #1;
        chk("ar.mreq_drop", bus.w_mreq, 32'd0);
        chk("ar.dack", bus.w_dack, 32'd0);
        bus.w_ireq = 1'b0; bus.w_dreq = 1'b0; bus.w_dwe = 1'b0;
        cyc();
        w_rst_n = 1'b1;
        cyc();
        chk("ar.idle_mreq", bus.w_mreq, 32'd0);
        chk("ar.idle_dack", bus.w_dack, 32'd0);
        // cnt must be back at 0: four data grants before the fetch
        run_starve("ar.stv", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
